// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the AXI-Stream switch scheduler and datapath.
package axis_switch_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

  localparam int OH_MAX = 64;

  // Index of the set bit in a one-hot vector (zero-extend narrower vectors).
  function automatic logic [5:0] onehot_to_idx(input logic [OH_MAX-1:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_switch_port_sched.sv
// Per-master packet scheduler: round-robin pick, lock until tlast beat.
// Optional source-stall timeout when AXIS_SCHED_TIMEOUT_EN is defined.
module axis_switch_port_sched
  import axis_switch_pkg::*;
#(
  parameter int PORTS = 4
`ifdef AXIS_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                     clk,
  input  logic                     resn,
  input  logic [PORTS-1:0]         req,
  input  logic [PORTS-1:0]         tvalid,
  input  logic [PORTS-1:0]         tlast,
  input  logic                     tready,
  output logic                     sel_valid,
  output logic [$clog2(PORTS)-1:0] sel_src,
  output logic                     err_timeout
);

  localparam int IDXW = $clog2(PORTS);
  localparam logic [IDXW:0] PORTS_W = (IDXW+1)'(PORTS);

  sched_state_t     state, state_nxt;
  logic [IDXW-1:0]  rr_ptr, winner, ptr_inc;
  logic [IDXW:0]    cand, inc_w;
  logic [PORTS-1:0] pick_oh;
  logic             found, lock, beat, expire;

  // First requester at or after rr_ptr, wrapping modulo PORTS.
  always_comb begin
    pick_oh = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < PORTS; i++) begin
      cand = {1'b0, rr_ptr} + (IDXW+1)'(i);
      if (cand >= PORTS_W) cand = cand - PORTS_W;
      if (!found && req[cand[IDXW-1:0]]) begin
        pick_oh = PORTS'(1) << cand;
        found   = 1'b1;
      end
    end
  end

  assign winner  = IDXW'(onehot_to_idx(OH_MAX'(pick_oh)));
  assign inc_w   = {1'b0, winner} + 1'b1;
  assign ptr_inc = (inc_w >= PORTS_W) ? '0 : inc_w[IDXW-1:0];

  assign sel_valid = (state == LOCKED);
  assign beat      = tvalid[sel_src] & tready;

  always_comb begin
    state_nxt = state;
    lock      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = LOCKED;
          lock      = 1'b1;
        end
      end
      LOCKED: begin
        if ((beat && tlast[sel_src]) || expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      sel_src <= '0;
    end else begin
      state <= state_nxt;
      if (lock) begin
        sel_src <= winner;
        rr_ptr  <= ptr_inc;
      end
    end
  end

`ifdef AXIS_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] stall_cnt;
  logic          err_q;

  // Only source-side stalls count; a master holding tready low is legitimate.
  assign expire = (state == LOCKED) && !tvalid[sel_src] && (stall_cnt == LIMIT_M1);

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= expire;
      if (state != LOCKED || beat || expire) stall_cnt <= '0;
      else if (!tvalid[sel_src])            stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: rtl/axis_switch_sched.sv
// AXI-Stream crossbar packet scheduler: tid decode, per-master arbiters, grant map.
// Optional stall timeout enabled by defining AXIS_SCHED_TIMEOUT_EN.
module axis_switch_sched
  import axis_switch_pkg::*;
#(
  parameter int PORTS          = 4,
  parameter int TID_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             resn,
  input  logic [PORTS-1:0]                 s_axis_tvalid,
  input  logic [PORTS*TID_WIDTH-1:0]       s_axis_tid,
  input  logic [PORTS-1:0]                 s_axis_tlast,
  input  logic [PORTS-1:0]                 m_axis_tready,
  output logic [PORTS-1:0]                 m_sel_valid,
  output logic [PORTS*$clog2(PORTS)-1:0]   m_sel_src,
  output logic [PORTS-1:0]                 s_grant,
  output logic [PORTS-1:0]                 bad_tid,
  output logic [PORTS-1:0]                 err_timeout
);

  localparam int IDXW = $clog2(PORTS);

  if (PORTS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axis_switch_sched: PORTS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [PORTS-1:0]     req [PORTS];
  logic [TID_WIDTH-1:0] tid;

  // Granted slaves are masked so a slave can never hold two masters.
  always_comb begin
    bad_tid = '0;
    tid     = '0;
    for (int m = 0; m < PORTS; m++) req[m] = '0;
    for (int f = 0; f < PORTS; f++) begin
      tid        = s_axis_tid[f*TID_WIDTH +: TID_WIDTH];
      bad_tid[f] = s_axis_tvalid[f] && (32'(tid) >= 32'(PORTS));
      for (int m = 0; m < PORTS; m++) begin
        req[m][f] = s_axis_tvalid[f] && !s_grant[f] && (32'(tid) == 32'(m));
      end
    end
  end

  always_comb begin
    s_grant = '0;
    for (int m = 0; m < PORTS; m++) begin
      if (m_sel_valid[m]) s_grant[m_sel_src[m*IDXW +: IDXW]] = 1'b1;
    end
  end

  for (genvar m = 0; m < PORTS; m++) begin : g_master
    axis_switch_port_sched #(
      .PORTS          (PORTS)
`ifdef AXIS_SCHED_TIMEOUT_EN
      , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_sched (
      .clk         (clk),
      .resn        (resn),
      .req         (req[m]),
      .tvalid      (s_axis_tvalid),
      .tlast       (s_axis_tlast),
      .tready      (m_axis_tready[m]),
      .sel_valid   (m_sel_valid[m]),
      .sel_src     (m_sel_src[m*IDXW +: IDXW]),
      .err_timeout (err_timeout[m])
    );
  end

endmodule

// File: tb/tb_axis_switch_sched.sv
// Directed bench for axis_switch_sched (PORTS=4, TID_WIDTH=8, TIMEOUT_CYCLES=5).
module tb_axis_switch_sched;

  logic        clk = 1'b0;
  logic        resn;
  logic [3:0]  s_axis_tvalid;
  logic [31:0] s_axis_tid;
  logic [3:0]  s_axis_tlast;
  logic [3:0]  m_axis_tready;
  logic [3:0]  m_sel_valid;
  logic [7:0]  m_sel_src;
  logic [3:0]  s_grant;
  logic [3:0]  bad_tid;
  logic [3:0]  err_timeout;

  int checks   = 0;
  int failures = 0;

  axis_switch_sched #(
    .PORTS          (4),
    .TID_WIDTH      (8),
    .TIMEOUT_CYCLES (5)
  ) dut (
    .clk           (clk),
    .resn          (resn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_sel_valid   (m_sel_valid),
    .m_sel_src     (m_sel_src),
    .s_grant       (s_grant),
    .bad_tid       (bad_tid),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int f, input logic v, input logic [7:0] t, input logic l);
    s_axis_tvalid[f]        = v;
    s_axis_tid[f*8 +: 8]    = t;
    s_axis_tlast[f]         = l;
  endtask

  function automatic logic [1:0] src_of(input int m);
    return m_sel_src[m*2 +: 2];
  endfunction

  initial begin
    resn          = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tid    = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 4'hF;
    step();
    step();
    chk("rst_sel_valid", 32'(m_sel_valid), 32'h0);
    chk("rst_sel_src",   32'(m_sel_src),   32'h0);
    chk("rst_grant",     32'(s_grant),     32'h0);
    chk("rst_bad_tid",   32'(bad_tid),     32'h0);
    chk("rst_err",       32'(err_timeout), 32'h0);
    resn = 1'b1;
    step();

    // Contention: slaves 0,1,2 -> master 3, 4-beat packets, grants 0,1,2.
    for (int f = 0; f < 3; f++) drive(f, 1'b1, 8'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("cont_lock%0d_valid", k), 32'(m_sel_valid), 32'h8);
      chk($sformatf("cont_lock%0d_src", k),   32'(src_of(3)),   32'(k));
      chk($sformatf("cont_lock%0d_grant", k), 32'(s_grant),     32'(1 << k));
      for (int b = 0; b < 4; b++) begin
        s_axis_tlast[k] = (b == 3);
        step();
        if (b < 3) chk($sformatf("cont_hold%0d_%0d", k, b), 32'(m_sel_valid[3]), 32'h1);
      end
      chk($sformatf("cont_bubble%0d", k),       32'(m_sel_valid), 32'h0);
      chk($sformatf("cont_bubble%0d_grant", k), 32'(s_grant),     32'h0);
      drive(k, 1'b0, 8'd0, 1'b0);
    end

    // rr_ptr[3] should now be 3: slave 3 beats slave 0; single-beat packets.
    drive(0, 1'b1, 8'd3, 1'b0);
    drive(3, 1'b1, 8'd3, 1'b1);
    step();
    chk("rr_ptr3_pick", 32'(src_of(3)),      32'd3);
    chk("rr_ptr3_valid", 32'(m_sel_valid),   32'h8);
    step();
    chk("single_beat_release", 32'(m_sel_valid), 32'h0);
    drive(3, 1'b0, 8'd0, 1'b0);
    s_axis_tlast[0] = 1'b1;
    step();
    chk("rr_wrap_pick", 32'(src_of(3)), 32'd0);
    step();
    chk("rr_wrap_release", 32'(m_sel_valid), 32'h0);
    drive(0, 1'b0, 8'd0, 1'b0);

    // Parallel connections: slave0->m2, slave1->m0 in the same cycle.
    drive(0, 1'b1, 8'd2, 1'b0);
    drive(1, 1'b1, 8'd0, 1'b0);
    step();
    chk("par_valid", 32'(m_sel_valid), 32'h5);
    chk("par_grant", 32'(s_grant),     32'h3);
    chk("par_src",   32'(m_sel_src),   32'h01);
    s_axis_tid[15:8] = 8'd2;
    step();
    chk("par_tid_change_valid", 32'(m_sel_valid), 32'h5);
    chk("par_tid_change_src",   32'(src_of(0)),   32'd1);
    s_axis_tlast[1:0] = 2'b11;
    step();
    chk("par_release", 32'(m_sel_valid), 32'h0);
    chk("par_src_held", 32'(m_sel_src),  32'h01);
    drive(0, 1'b0, 8'd0, 1'b0);
    drive(1, 1'b0, 8'd0, 1'b0);

    // Backpressure on master 1 for 10 cycles with tlast pending.
    drive(2, 1'b1, 8'd1, 1'b0);
    step();
    chk("bp_lock_src", 32'(src_of(1)), 32'd2);
    step();
    m_axis_tready[1] = 1'b0;
    s_axis_tlast[2]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), 32'({err_timeout, m_sel_valid[1]}), 32'h1);
    end
    m_axis_tready[1] = 1'b1;
    step();
    chk("bp_release", 32'(m_sel_valid[1]), 32'h0);
    drive(2, 1'b0, 8'd0, 1'b0);

    // Out-of-range tid on slave 3 alongside normal traffic on slave 2.
    drive(3, 1'b1, 8'd7, 1'b0);
    drive(2, 1'b1, 8'd1, 1'b1);
    #1;
    chk("bad_tid_comb", 32'(bad_tid), 32'h8);
    step();
    chk("bad_tid_valid", 32'(m_sel_valid), 32'h2);
    chk("bad_tid_grant", 32'(s_grant),     32'h4);
    chk("bad_tid_src",   32'(src_of(1)),   32'd2);
    chk("bad_tid_hold",  32'(bad_tid),     32'h8);
    step();
    chk("bad_tid_release", 32'(m_sel_valid), 32'h0);
    drive(2, 1'b0, 8'd0, 1'b0);
    drive(3, 1'b0, 8'd0, 1'b0);
    #1;
    chk("bad_tid_clear", 32'(bad_tid), 32'h0);

    // Source stall: slave1->m3 drops tvalid after two beats.
    drive(1, 1'b1, 8'd3, 1'b0);
    step();
    chk("to_lock_src", 32'(src_of(3)), 32'd1);
    step();
    step();
    s_axis_tvalid[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("to_stall%0d", i), 32'({err_timeout, m_sel_valid}), 32'h08);
    end
    step();
`ifdef AXIS_SCHED_TIMEOUT_EN
    chk("to_fire", 32'({err_timeout, m_sel_valid}), 32'h80);
    step();
    chk("to_pulse_once", 32'({err_timeout, m_sel_valid}), 32'h00);
    drive(1, 1'b0, 8'd0, 1'b0);
`else
    chk("to_held5", 32'({err_timeout, m_sel_valid}), 32'h08);
    for (int i = 0; i < 5; i++) step();
    chk("to_held10", 32'({err_timeout, m_sel_valid}), 32'h08);
    drive(1, 1'b1, 8'd3, 1'b1);
    step();
    chk("to_release", 32'(m_sel_valid), 32'h0);
    drive(1, 1'b0, 8'd0, 1'b0);
`endif

    // Async reset mid-packet; rr_ptr[1] is 1 before reset, 0 after.
    drive(0, 1'b1, 8'd1, 1'b0);
    step();
    chk("ar_lock_src", 32'(src_of(1)), 32'd0);
    #3;
    resn = 1'b0;
    #1;
    chk("ar_valid", 32'(m_sel_valid), 32'h0);
    chk("ar_grant", 32'(s_grant),     32'h0);
    chk("ar_src",   32'(m_sel_src),   32'h0);
    chk("ar_err",   32'(err_timeout), 32'h0);
    step();
    resn = 1'b1;
    drive(3, 1'b1, 8'd1, 1'b0);
    step();
    chk("ar_rr_restart", 32'(src_of(1)), 32'd0);
    chk("ar_rr_grant",   32'(s_grant),   32'h1);
    drive(0, 1'b0, 8'd0, 1'b0);
    drive(3, 1'b0, 8'd0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
